maquina_estados_mascota: RTL and testbench

//  Pet-behaviour FSM directly downstream of the modes block. Consumes the four 2-bit need levels
//  (animo, energia, descanso, medicina) and the 5-second feed/medicate completion pulses.

---
 rtl/maquina_estados_mascota_pkg.sv | 49 ++++
 rtl/maquina_estados_mascota_divisor_tick.sv | 26 ++
 rtl/maquina_estados_mascota.sv | 145 ++++++++++++++
 tb/tb_maquina_estados_mascota.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maquina_estados_mascota_pkg.sv
// Shared definitions for the pet-behaviour FSM: state codes, level thresholds
// and the target-state rule. The display decoder imports this package too.
package maquina_estados_mascota_pkg;

  localparam int ESTADO_W = 3;

  localparam logic [ESTADO_W-1:0] FELIZ      = 3'd0;
  localparam logic [ESTADO_W-1:0] TRISTE     = 3'd1;
  localparam logic [ESTADO_W-1:0] CANSADO    = 3'd2;
  localparam logic [ESTADO_W-1:0] HAMBRIENTO = 3'd3;
  localparam logic [ESTADO_W-1:0] ENFERMO    = 3'd4;
  localparam logic [ESTADO_W-1:0] MUERTO     = 3'd5;
  localparam logic [ESTADO_W-1:0] TEST       = 3'd6;

  localparam logic [1:0] LOW_TH = 2'd1;
  localparam logic [1:0] OK_TH  = 2'd2;

  function automatic logic es_alarma(input logic [ESTADO_W-1:0] code);
    return (code >= TRISTE) && (code <= ENFERMO);
  endfunction

  // The current alarm state holds until its own level recovers to OK_TH;
  // otherwise the most urgent low need wins.
  function automatic logic [ESTADO_W-1:0] calc_objetivo(
    input logic [ESTADO_W-1:0] actual,
    input logic [1:0]          animo,
    input logic [1:0]          energia,
    input logic [1:0]          descanso,
    input logic [1:0]          medicina
  );
    logic [1:0]          propio;
    logic [ESTADO_W-1:0] obj;
    case (actual)
      TRISTE:     propio = animo;
      CANSADO:    propio = descanso;
      HAMBRIENTO: propio = energia;
      ENFERMO:    propio = medicina;
      default:    propio = OK_TH;
    endcase
    if (medicina <= LOW_TH)      obj = ENFERMO;
    else if (energia <= LOW_TH)  obj = HAMBRIENTO;
    else if (descanso <= LOW_TH) obj = CANSADO;
    else if (animo <= LOW_TH)    obj = TRISTE;
    else                         obj = FELIZ;
    if (es_alarma(actual) && (propio < OK_TH)) obj = actual;
    return obj;
  endfunction

endpackage

// File: rtl/maquina_estados_mascota_divisor_tick.sv
// Free-running prescaler: tick is high for one clock out of every CLK_HZ,
// decoded from the counter register so it carries no input logic.
module divisor_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                CNT_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0]  ULTIMO = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk) begin
    if (reset)              cnt <= '0;
    else if (cnt == ULTIMO) cnt <= '0;
    else                    cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == ULTIMO);

endmodule

// File: rtl/maquina_estados_mascota.sv
// Pet-behaviour FSM: need levels -> pet state, feed/medicate enables, alarm
// and latched death. Optional display-walk TEST mode under MASCOTA_TEST_EN.
module maquina_estados_mascota
  import maquina_estados_mascota_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEATH_S     = 30,
  parameter int DWELL_TICKS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                test,
  input  logic [1:0]          nivel_animo,
  input  logic [1:0]          nivel_energia,
  input  logic [1:0]          nivel_descanso,
  input  logic [1:0]          nivel_medicina,
  input  logic                senal_5seg_energia,
  input  logic                senal_5seg_medicina,
  output logic [ESTADO_W-1:0] estado,
  output logic                activo_comida,
  output logic                activo_medicina,
  output logic                alarma,
  output logic                muerto
);

  localparam int                 DWELL_W   = $clog2(DWELL_TICKS + 1);
  localparam int                 DEATH_W   = $clog2(DEATH_S + 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_TICKS);
  localparam logic [DEATH_W-1:0] DEATH_MAX = DEATH_W'(DEATH_S);

  logic                tick;
  logic [ESTADO_W-1:0] estado_q, estado_d, objetivo, display_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d, dwell_inc;
  logic [DEATH_W-1:0]  death_q, death_d, death_inc;
  logic                algun_cero, pulso_ok;

  divisor_tick #(.CLK_HZ(CLK_HZ)) u_divisor_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign algun_cero = (nivel_animo == 2'd0) || (nivel_energia == 2'd0) ||
                      (nivel_descanso == 2'd0) || (nivel_medicina == 2'd0);
  assign pulso_ok   = ((estado_q == HAMBRIENTO) && senal_5seg_energia) ||
                      ((estado_q == ENFERMO) && senal_5seg_medicina);
  assign objetivo   = calc_objetivo(estado_q, nivel_animo, nivel_energia,
                                    nivel_descanso, nivel_medicina);
  // Both counters stay below their maximum outside MUERTO, so +1 never wraps.
  assign dwell_inc  = dwell_q + DWELL_W'(1);
  assign death_inc  = death_q + DEATH_W'(1);

`ifndef MASCOTA_TEST_EN
  logic test_unused;
  assign test_unused = test;
`endif

  // Event priority: death > test > 5 s pulse > dwell transition.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it
    // unassigned and infer a latch.
    estado_d = estado_q;
    dwell_d  = dwell_q;
    death_d  = death_q;
    if (estado_q == MUERTO) begin
      estado_d = MUERTO;
`ifdef MASCOTA_TEST_EN
    end else if (estado_q == TEST) begin
      if (test) begin
        estado_d = FELIZ;
        dwell_d  = '0;
        death_d  = '0;
      end
`endif
    end else begin
      if (tick) death_d = algun_cero ? ((death_q == DEATH_MAX) ? DEATH_MAX : death_inc) : '0;
      if (death_d == DEATH_MAX) begin
        estado_d = MUERTO;
        dwell_d  = '0;
`ifdef MASCOTA_TEST_EN
      end else if (test) begin
        estado_d = TEST;
        dwell_d  = '0;
`endif
      end else if (pulso_ok) begin
        estado_d = FELIZ;
        dwell_d  = '0;
      end else if (tick) begin
        if (objetivo == estado_q) begin
          dwell_d = '0;
        end else if (dwell_inc == DWELL_MAX) begin
          estado_d = objetivo;
          dwell_d  = '0;
        end else begin
          dwell_d = dwell_inc;
        end
      end
    end
  end

`ifdef MASCOTA_TEST_EN
  // walk_q == TEST shows code 6 until the first tick, then cycles 0..5.
  logic [ESTADO_W-1:0] walk_q, walk_d;

  always_comb begin
    walk_d = walk_q;
    if ((estado_d == TEST) && (estado_q != TEST))
      walk_d = TEST;
    else if ((estado_q == TEST) && tick)
      walk_d = (walk_q >= MUERTO) ? FELIZ : walk_q + ESTADO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) walk_q <= FELIZ;
    else       walk_q <= walk_d;
  end

  assign display_d = (estado_d == TEST) ? walk_d : estado_d;
`else
  assign display_d = estado_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q        <= FELIZ;
      dwell_q         <= '0;
      death_q         <= '0;
      estado          <= FELIZ;
      activo_comida   <= 1'b0;
      activo_medicina <= 1'b0;
      alarma          <= 1'b0;
      muerto          <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      dwell_q         <= dwell_d;
      death_q         <= death_d;
      estado          <= display_d;
      activo_comida   <= (estado_d == HAMBRIENTO);
      activo_medicina <= (estado_d == ENFERMO);
      alarma          <= es_alarma(display_d);
      muerto          <= (display_d == MUERTO);
    end
  end

endmodule

// File: tb/tb_maquina_estados_mascota.sv
// Self-checking bench for maquina_estados_mascota with a need-table reference model.
module tb_maquina_estados_mascota;

  localparam int CLK_HZ      = 10;
  localparam int DEATH_S     = 4;
  localparam int DWELL_TICKS = 2;
`ifdef MASCOTA_TEST_EN
  localparam bit TEST_EN = 1'b1;
`else
  localparam bit TEST_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       test = 1'b0;
  logic [1:0] nivel_animo = 2'd3, nivel_energia = 2'd3;
  logic [1:0] nivel_descanso = 2'd3, nivel_medicina = 2'd3;
  logic       senal_5seg_energia = 1'b0, senal_5seg_medicina = 1'b0;
  logic [2:0] estado;
  logic       activo_comida, activo_medicina, alarma, muerto;
  logic [6:0] obs;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_state = 0, m_dwell = 0, m_death = 0, m_edges = 0, m_walk = -1;
  bit m_in_test = 1'b0;

  maquina_estados_mascota #(
    .CLK_HZ(CLK_HZ), .DEATH_S(DEATH_S), .DWELL_TICKS(DWELL_TICKS)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .test                (test),
    .nivel_animo         (nivel_animo),
    .nivel_energia       (nivel_energia),
    .nivel_descanso      (nivel_descanso),
    .nivel_medicina      (nivel_medicina),
    .senal_5seg_energia  (senal_5seg_energia),
    .senal_5seg_medicina (senal_5seg_medicina),
    .estado              (estado),
    .activo_comida       (activo_comida),
    .activo_medicina     (activo_medicina),
    .alarma              (alarma),
    .muerto              (muerto)
  );

  assign obs = {estado, activo_comida, activo_medicina, alarma, muerto};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Needs indexed by the alarm state they cause: 1 animo, 2 descanso, 3 energia, 4 medicina.
  function automatic int objetivo_modelo();
    int necesidad[5];
    necesidad[0] = 3;
    necesidad[1] = int'(nivel_animo);
    necesidad[2] = int'(nivel_descanso);
    necesidad[3] = int'(nivel_energia);
    necesidad[4] = int'(nivel_medicina);
    if (m_state >= 1 && m_state <= 4 && necesidad[m_state] <= 1) return m_state;
    for (int s = 4; s >= 1; s--)
      if (necesidad[s] <= 1) return s;
    return 0;
  endfunction

  function automatic void model_edge();
    bit tk, cero;
    int obj;
    if (reset) begin
      m_state = 0; m_dwell = 0; m_death = 0; m_edges = 0; m_in_test = 1'b0; m_walk = -1;
      return;
    end
    m_edges++;
    tk   = (m_edges % CLK_HZ) == 0;
    cero = (nivel_animo == 0) || (nivel_energia == 0) || (nivel_descanso == 0) || (nivel_medicina == 0);
    if (m_state == 5) return;
    if (m_in_test) begin
      if (test) begin
        m_in_test = 1'b0; m_state = 0; m_dwell = 0; m_death = 0;
      end else if (tk) begin
        m_walk = (m_walk + 1) % 6;
      end
      return;
    end
    if (tk) m_death = cero ? ((m_death < DEATH_S) ? m_death + 1 : DEATH_S) : 0;
    if (m_death == DEATH_S) begin
      m_state = 5; m_dwell = 0;
      return;
    end
    if (TEST_EN && test) begin
      m_in_test = 1'b1; m_walk = -1; m_dwell = 0;
      return;
    end
    if ((m_state == 3 && senal_5seg_energia) || (m_state == 4 && senal_5seg_medicina)) begin
      m_state = 0; m_dwell = 0;
      return;
    end
    if (tk) begin
      obj = objetivo_modelo();
      if (obj == m_state) m_dwell = 0;
      else if (m_dwell + 1 >= DWELL_TICKS) begin
        m_state = obj; m_dwell = 0;
      end else m_dwell++;
    end
  endfunction

  function automatic logic [6:0] exp_vec();
    int d;
    logic [2:0] d3;
    logic ac, am, al, mu;
    d  = m_in_test ? ((m_walk < 0) ? 6 : m_walk) : m_state;
    d3 = 3'(d);
    ac = (!m_in_test && m_state == 3);
    am = (!m_in_test && m_state == 4);
    al = (d >= 1 && d <= 4);
    mu = (d == 5);
    return {d3, ac, am, al, mu};
  endfunction

  function automatic logic [1:0] rnd_nivel();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return 2'd0;
    if (r <= 4) return 2'd1;
    if (r <= 8) return 2'd2;
    return 2'd3;
  endfunction

  task automatic ciclo();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_niveles(input logic [1:0] a, input logic [1:0] e,
                             input logic [1:0] d, input logic [1:0] m);
    nivel_animo = a; nivel_energia = e; nivel_descanso = d; nivel_medicina = m;
  endtask

  task automatic test_reset();
    set_niveles(3, 3, 3, 3);
    reset = 1'b1;
    repeat (3) ciclo();
    vectors++;
    if (obs !== 7'b000_0000) begin
      miscompares++;
      $display("FAIL reset_state: got %b want 0000000", obs);
    end
    reset = 1'b0;
    for (int i = 0; i < 20 * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (estado !== 3'd0 || alarma !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold_end: got estado=%0d alarma=%b want 0/0", estado, alarma);
    end
  endtask

  task automatic test_hambre();
    nivel_energia = 2'd1;
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL hambre_dwell cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (estado !== 3'd3 || activo_comida !== 1'b1) begin
      miscompares++;
      $display("FAIL hambre_entry: got estado=%0d comida=%b want 3/1", estado, activo_comida);
    end
    senal_5seg_energia = 1'b1;
    ciclo();
    senal_5seg_energia = 1'b0;
    vectors++;
    if (estado !== 3'd0 || activo_comida !== 1'b0) begin
      miscompares++;
      $display("FAIL hambre_fed: got estado=%0d comida=%b want 0/0", estado, activo_comida);
    end
    nivel_energia = 2'd3;
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL hambre_after cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_prioridad();
    set_niveles(3, 1, 3, 1);
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL prio_enter cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (estado !== 3'd4 || activo_medicina !== 1'b1 || activo_comida !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_enfermo: got estado=%0d med=%b com=%b want 4/1/0", estado, activo_medicina, activo_comida);
    end
    nivel_medicina = 2'd2;
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL prio_leave cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (estado !== 3'd3) begin
      miscompares++;
      $display("FAIL prio_hambriento: got estado=%0d want 3", estado);
    end
    set_niveles(3, 3, 3, 3);
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL prio_recover cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_muerte();
    nivel_descanso = 2'd0;
    for (int i = 0; i < DEATH_S * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL death_count cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (estado !== 3'd5 || muerto !== 1'b1 || alarma !== 1'b0) begin
      miscompares++;
      $display("FAIL death_enter: got estado=%0d muerto=%b alarma=%b want 5/1/0", estado, muerto, alarma);
    end
    set_niveles(3, 3, 3, 3);
    test = 1'b1; senal_5seg_energia = 1'b1; senal_5seg_medicina = 1'b1;
    ciclo();
    test = 1'b0; senal_5seg_energia = 1'b0; senal_5seg_medicina = 1'b0;
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (estado !== 3'd5 || muerto !== 1'b1) begin
        miscompares++;
        $display("FAIL death_absorb cyc=%0d: got estado=%0d muerto=%b want 5/1", i, estado, muerto);
      end
    end
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    vectors++;
    if (obs !== 7'b000_0000) begin
      miscompares++;
      $display("FAIL death_reset: got %b want 0000000", obs);
    end
  endtask

  task automatic test_filtro();
    nivel_animo = 2'd1;
    for (int i = 0; i < CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (estado !== 3'd0 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL dwell_filter_low cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    nivel_animo = 2'd3;
    for (int i = 0; i < 2 * CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (estado !== 3'd0 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL dwell_filter_high cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_modo_test();
    test = 1'b1;
    ciclo();
    test = 1'b0;
`ifdef MASCOTA_TEST_EN
    vectors++;
    if (estado !== 3'd6 || alarma !== 1'b0 || muerto !== 1'b0) begin
      miscompares++;
      $display("FAIL test_enter: got estado=%0d want 6", estado);
    end
    for (int j = 0; j < 7; j++) begin
      for (int i = 0; i < CLK_HZ; i++) begin
        ciclo();
        vectors++;
        if (obs !== exp_vec()) begin
          miscompares++;
          $display("FAIL test_walk_cycle step=%0d cyc=%0d: got %b want %b", j, i, obs, exp_vec());
        end
      end
      vectors++;
      if (estado !== 3'(j % 6) || activo_comida !== 1'b0 || activo_medicina !== 1'b0) begin
        miscompares++;
        $display("FAIL test_walk step=%0d: got estado=%0d want %0d", j, estado, j % 6);
      end
    end
    test = 1'b1;
    ciclo();
    test = 1'b0;
    vectors++;
    if (obs !== 7'b000_0000) begin
      miscompares++;
      $display("FAIL test_exit: got %b want 0000000", obs);
    end
`else
    vectors++;
    if (obs !== 7'b000_0000) begin
      miscompares++;
      $display("FAIL test_ignored: got %b want 0000000", obs);
    end
`endif
    for (int i = 0; i < CLK_HZ; i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL test_after cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  // Feed pulse lands on the very edge where the death counter saturates.
  task automatic test_back_to_back();
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    set_niveles(3, 0, 3, 3);
    for (int i = 0; i < 100 && !(m_death == DEATH_S - 1 && (m_edges % CLK_HZ) == CLK_HZ - 1); i++) begin
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_approach cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    vectors++;
    if (estado !== 3'd3) begin
      miscompares++;
      $display("FAIL b2b_hungry: got estado=%0d want 3", estado);
    end
    senal_5seg_energia = 1'b1;
    ciclo();
    senal_5seg_energia = 1'b0;
    vectors++;
    if (estado !== 3'd5 || muerto !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_death_wins: got estado=%0d muerto=%b want 5/1", estado, muerto);
    end
    set_niveles(3, 3, 3, 3);
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
  endtask

  task automatic test_aleatorio();
    int dead_cycles;
    dead_cycles = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 13 == 0) set_niveles(rnd_nivel(), rnd_nivel(), rnd_nivel(), rnd_nivel());
      senal_5seg_energia  = ($urandom_range(0, 19) == 0);
      senal_5seg_medicina = ($urandom_range(0, 19) == 0);
      test                = ($urandom_range(0, 149) == 0);
      dead_cycles         = (m_state == 5) ? dead_cycles + 1 : 0;
      reset               = (dead_cycles > 20) || ($urandom_range(0, 499) == 0);
      ciclo();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d: got %b want %b", i, obs, exp_vec());
      end
    end
    reset = 1'b0; test = 1'b0;
    senal_5seg_energia = 1'b0; senal_5seg_medicina = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hambre();
    test_prioridad();
    test_muerte();
    test_filtro();
    test_modo_test();
    test_back_to_back();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
